// File: rtl/jtag_led_pkg.sv
// Shared constants for the JTAG LED controller: opcodes, frame layout, decode helpers.
package jtag_led_pkg;

  localparam int FRAME_LEN = 8;
  localparam int OP_LSB    = 6;
  localparam int ADDR_LSB  = 4;
  localparam int DATA_LSB  = 0;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_SCAN  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UPDATE
  } jstate_e;

  // Word loaded into the shift register on CAPTURE, MSB first as listed.
  typedef struct packed {
    logic [1:0] row_ptr;
    logic       frame_err;
    logic       scan_en;
    logic [3:0] rd_data;
  } status_t;

  function automatic jstate_e decode_state(input logic upd, input logic ce, input logic shift);
    jstate_e st;
    st = ST_IDLE;
    if (upd)
      st = ST_UPDATE;
    else if (ce && !shift)
      st = ST_CAPTURE;
    else if (ce)
      st = ST_SHIFT;
    return st;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] r;
    r      = 4'b0000;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/led_row_scanner.sv
// Row multiplexer: dwell counter and row pointer advanced in Run-Test/Idle, plus registered LED drive.
// Outputs follow the row pointer one JTCK edge later.
module led_row_scanner
  import jtag_led_pkg::*;
#(
  parameter int DWELL = 16
) (
  input  logic        JTCK,
  input  logic        JRSTN,
  input  logic        scan_en,
  input  logic        scan_load,
  input  logic        rti,
  input  logic [15:0] row_bits,
  output logic [1:0]  row_ptr,
  output logic [3:0]  leds_rows,
  output logic [3:0]  leds_columns
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [7:0] dwell_cnt;

  always_ff @(posedge JTCK) begin
    if (!JRSTN) begin
      dwell_cnt    <= 8'd0;
      row_ptr      <= 2'd0;
      leds_rows    <= 4'b0001;
      leds_columns <= 4'd0;
    end else begin
      leds_rows    <= onehot4(row_ptr);
      leds_columns <= row_bits[{row_ptr, 2'b00} +: 4];
      // A SCAN command restarts the sweep and wins over a coincident dwell advance.
      if (scan_load) begin
        dwell_cnt <= 8'd0;
        row_ptr   <= 2'd0;
      end else if (scan_en && rti) begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_cnt <= 8'd0;
          row_ptr   <= row_ptr + 2'd1;
        end else begin
          dwell_cnt <= dwell_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/jtag_led_ctrl.sv
// JTAG chain-2 LED controller: 8-bit command frames shifted LSB first drive a 4x4 scanned LED matrix.
// Commands take effect on the UPDATE edge; LED outputs follow one edge later.
module jtag_led_ctrl
  import jtag_led_pkg::*;
#(
  parameter int DWELL = 16
) (
  input  logic       JTCK,
  input  logic       JRSTN,
  input  logic       JTDI,
  input  logic       JSHIFT,
  input  logic       JUPDATE,
  input  logic       JRTI2,
  input  logic       JCE2,
  output logic       JTD2,
  output logic [3:0] LEDS_columns,
  output logic [3:0] LEDS_rows
);

  logic [7:0]  shift_reg;
  logic [3:0]  shift_cnt;
  logic [15:0] row_bits;
  logic        scan_en;
  logic        frame_err;
  logic [3:0]  rd_data;
  logic [1:0]  row_ptr;

  jstate_e     st;
  op_e         f_op;
  logic [1:0]  f_addr;
  logic [3:0]  f_data;
  logic        frame_ok;
  logic        scan_load;
  status_t     status;

  assign st       = decode_state(JUPDATE, JCE2, JSHIFT);
  assign f_op     = op_e'(shift_reg[OP_LSB +: 2]);
  assign f_addr   = shift_reg[ADDR_LSB +: 2];
  assign f_data   = shift_reg[DATA_LSB +: 4];
  assign frame_ok = (shift_cnt == 4'(FRAME_LEN));

  assign scan_load = (st == ST_UPDATE) && frame_ok && (f_op == OP_SCAN);

  always_comb begin
    status           = '0;
    status.row_ptr   = row_ptr;
    status.frame_err = frame_err;
    status.scan_en   = scan_en;
    status.rd_data   = rd_data;
  end

  always_ff @(posedge JTCK) begin
    if (!JRSTN) begin
      shift_reg <= 8'd0;
      shift_cnt <= 4'd0;
      row_bits  <= 16'd0;
      scan_en   <= 1'b0;
      frame_err <= 1'b0;
      rd_data   <= 4'd0;
      JTD2      <= 1'b0;
    end else begin
      case (st)
        ST_CAPTURE: begin
          shift_reg <= status;
          shift_cnt <= 4'd0;
        end
        ST_SHIFT: begin
          JTD2      <= shift_reg[0];
          shift_reg <= {JTDI, shift_reg[7:1]};
          // Saturation keeps oversized frames from aliasing back to a valid length.
          if (shift_cnt != 4'hF)
            shift_cnt <= shift_cnt + 4'd1;
        end
        ST_UPDATE: begin
          if (frame_ok) begin
            frame_err <= 1'b0;
            case (f_op)
              OP_WRITE: row_bits[{f_addr, 2'b00} +: 4] <= f_data;
              OP_READ:  rd_data <= row_bits[{f_addr, 2'b00} +: 4];
              OP_SCAN:  scan_en <= f_data[0];
              default:  ;
            endcase
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  led_row_scanner #(
    .DWELL(DWELL)
  ) u_scanner (
    .JTCK         (JTCK),
    .JRSTN        (JRSTN),
    .scan_en      (scan_en),
    .scan_load    (scan_load),
    .rti          (JRTI2),
    .row_bits     (row_bits),
    .row_ptr      (row_ptr),
    .leds_rows    (LEDS_rows),
    .leds_columns (LEDS_columns)
  );

endmodule

// File: tb/tb_jtag_led_ctrl.sv
// Directed and randomized bench for jtag_led_ctrl against a queue-based behavioural model.
module tb_jtag_led_ctrl;

  localparam int DWELL = 4;

  logic       JTCK = 1'b0;
  logic       JRSTN = 1'b0;
  logic       JTDI = 1'b0;
  logic       JSHIFT = 1'b0;
  logic       JUPDATE = 1'b0;
  logic       JRTI2 = 1'b0;
  logic       JCE2 = 1'b0;
  logic       JTD2;
  logic [3:0] LEDS_columns;
  logic [3:0] LEDS_rows;

  jtag_led_ctrl #(.DWELL(DWELL)) dut (
    .JTCK         (JTCK),
    .JRSTN        (JRSTN),
    .JTDI         (JTDI),
    .JSHIFT       (JSHIFT),
    .JUPDATE      (JUPDATE),
    .JRTI2        (JRTI2),
    .JCE2         (JCE2),
    .JTD2         (JTD2),
    .LEDS_columns (LEDS_columns),
    .LEDS_rows    (LEDS_rows)
  );

  always #5 JTCK = ~JTCK;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [3:0] m_rows [4];
  logic       m_scan, m_err, m_jtd2;
  logic [3:0] m_rd, m_lrows, m_lcols;
  logic [1:0] m_ptr;
  int         m_dwell, m_cnt;
  bit         sr[$];

  bit g_rti = 0;
  bit g_rand_rti = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit ce, input bit sh, input bit up, input bit rti,
                            input bit tdi, input bit rstn);
    logic [7:0] f;
    logic       old_scan;
    bit         scan_cmd;
    if (!rstn) begin
      for (int i = 0; i < 4; i++) m_rows[i] = 4'd0;
      m_scan = 0; m_err = 0; m_jtd2 = 0; m_rd = 4'd0; m_ptr = 2'd0;
      m_dwell = 0; m_cnt = 0; m_lrows = 4'b0001; m_lcols = 4'd0;
      sr.delete();
      repeat (8) sr.push_back(1'b0);
      return;
    end
    m_lrows  = 4'(1 << m_ptr);
    m_lcols  = m_rows[m_ptr];
    old_scan = m_scan;
    scan_cmd = 0;
    if (up) begin
      if (m_cnt == 8) begin
        for (int i = 0; i < 8; i++) f[i] = sr[i];
        m_err = 0;
        case (f[7:6])
          2'd1: m_rows[f[5:4]] = f[3:0];
          2'd2: m_rd = m_rows[f[5:4]];
          2'd3: begin m_scan = f[0]; scan_cmd = 1; end
          default: ;
        endcase
      end else begin
        m_err = 1;
      end
    end else if (ce && !sh) begin
      f = {m_ptr, m_err, m_scan, m_rd};
      sr.delete();
      for (int i = 0; i < 8; i++) sr.push_back(f[i]);
      m_cnt = 0;
    end else if (ce && sh) begin
      m_jtd2 = sr.pop_front();
      sr.push_back(tdi);
      if (m_cnt < 15) m_cnt++;
    end
    if (scan_cmd) begin
      m_ptr = 2'd0; m_dwell = 0;
    end else if (old_scan && rti) begin
      if (m_dwell == DWELL - 1) begin
        m_dwell = 0;
        m_ptr   = m_ptr + 2'd1;
      end else begin
        m_dwell++;
      end
    end
  endtask

  task automatic step(input bit ce, input bit sh, input bit up, input bit tdi, input bit rstn);
    bit rti;
    rti = g_rand_rti ? bit'($urandom_range(0, 1)) : g_rti;
    JCE2 = ce; JSHIFT = sh; JUPDATE = up; JTDI = tdi; JRTI2 = rti; JRSTN = rstn;
    @(posedge JTCK);
    model_edge(ce, sh, up, rti, tdi, rstn);
    #1;
    chk("jtd2", 8'(JTD2), 8'(m_jtd2));
    chk("leds_rows", 8'(LEDS_rows), 8'(m_lrows));
    chk("leds_cols", 8'(LEDS_columns), 8'(m_lcols));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic capture();
    step(1, 0, 0, 0, 1);
  endtask

  task automatic update();
    step(0, 0, 1, 0, 1);
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, v[i], 1);
  endtask

  task automatic shift_collect(output logic [7:0] got);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 1'b0, 1);
      got[i] = JTD2;
    end
  endtask

  task automatic send_frame(input logic [7:0] v);
    capture();
    shift_bits({8'd0, v}, 8);
    update();
  endtask

  initial begin
    logic [7:0]  got;
    logic [3:0]  e;
    logic [15:0] rv;
    int          len, r, kind;

    // Reset
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_jtd2", 8'(JTD2), 8'h0);
    chk("rst_rows", 8'(LEDS_rows), 8'h1);
    chk("rst_cols", 8'(LEDS_columns), 8'h0);

    // WRITE row1=A straight after reset; row 0 still shown
    shift_bits(16'h005A, 8);
    update();
    idle(2);
    chk("write_cols_row0", 8'(LEDS_columns), 8'h0);
    chk("write_rows_row0", 8'(LEDS_rows), 8'h1);

    // READ row1, capture, shift out status
    send_frame(8'h90);
    capture();
    shift_collect(got);
    chk("read_status", got, 8'h0A);

    // Short frame flags an error, NOP clears it
    capture();
    shift_bits(16'h007F, 7);
    update();
    capture();
    shift_collect(got);
    chk("short_err_bit5", 8'(got[5]), 8'h1);
    chk("short_status", got, 8'h2A);
    send_frame(8'h00);
    capture();
    shift_collect(got);
    chk("nop_clear", got, 8'h0A);

    // Oversized frame (16 bits) rejected
    capture();
    shift_bits(16'h41C1, 16);
    update();
    capture();
    shift_collect(got);
    chk("long_status", got, 8'h2A);

    // Scan sweep with rows 1,2,4,8
    send_frame(8'h41);
    send_frame(8'h52);
    send_frame(8'h64);
    send_frame(8'h78);
    g_rti = 1;
    send_frame(8'hC1);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      e = 4'(1 << ((i / 4) % 4));
      chk("scan_rows", 8'(LEDS_rows), 8'(e));
      chk("scan_cols", 8'(LEDS_columns), 8'(e));
    end
    g_rti = 0;
    idle(5);
    chk("freeze_rows", 8'(LEDS_rows), 8'h2);
    chk("freeze_cols", 8'(LEDS_columns), 8'h2);
    g_rti = 1;
    idle(6);
    // SCAN coincident with dwell advance restarts at row 0
    send_frame(8'hC1);
    idle(2);
    chk("rescan_rows", 8'(LEDS_rows), 8'h1);
    g_rti = 0;
    send_frame(8'hC0);

    // Reset in the middle of a frame
    capture();
    shift_bits(16'h0055, 4);
    step(1, 1, 0, 1, 0);
    chk("midrst_jtd2", 8'(JTD2), 8'h0);
    chk("midrst_rows", 8'(LEDS_rows), 8'h1);
    chk("midrst_cols", 8'(LEDS_columns), 8'h0);
    send_frame(8'h43);
    idle(2);
    chk("post_rst_cols", 8'(LEDS_columns), 8'h3);
    chk("post_rst_rows", 8'(LEDS_rows), 8'h1);

    // Randomized traffic
    g_rand_rti = 1;
    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 9);
      rv   = 16'($urandom);
      if (kind == 0) begin
        capture();
        shift_bits(rv, $urandom_range(0, 7));
        step(1, 1, 0, 0, 0);
      end else if (kind <= 5) begin
        r   = $urandom_range(0, 9);
        len = (r < 7) ? 8 : (r == 7) ? 7 : (r == 8) ? 9 : 16;
        capture();
        shift_bits(rv, len);
        update();
      end else if (kind <= 7) begin
        capture();
        shift_collect(got);
      end else begin
        idle($urandom_range(1, 12));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_led_ctrl.md
JTAG_LED_CTRL -- requirements
Module: jtag_led_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 16, meaning JTCK cycles in Run-Test/Idle per scanned row (range 2..256).
REQ-002 SHALL have port JTCK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port JRSTN, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port JTDI, input, 1, serial data in, LSB first.
REQ-005 SHALL have ports JSHIFT, JUPDATE, JRTI2, JCE2, each input, 1: shift state, update strobe, Run-Test/Idle, chain-2 enable.
REQ-006 SHALL have port JTD2, output, 1, registered serial data out.
REQ-007 SHALL have ports LEDS_columns, output, 4, column drive; LEDS_rows, output, 4, one-hot row select.

Function
REQ-008 SHALL hold an 8-bit shift register, a 4-bit shift counter saturating at 15, four 4-bit row registers, scan_en, frame_err, 4-bit rd_data, 2-bit row pointer, and a dwell counter.
REQ-009 SHALL decode per edge, by priority: JUPDATE=1 -> UPDATE; else JCE2=1 and JSHIFT=0 -> CAPTURE; else JCE2=1 and JSHIFT=1 -> SHIFT; else IDLE.
REQ-010 CAPTURE SHALL load shift register with {row_ptr[1:0], frame_err, scan_en, rd_data[3:0]} and clear the shift counter.
REQ-011 SHALL, in SHIFT, drive JTD2 <= shift_reg[0], shift_reg <= {JTDI, shift_reg[7:1]}, and increment the shift counter; JTD2 SHALL hold its value in all other states.
REQ-012 SHALL, in UPDATE, decode frame {op[7:6], addr[5:4], data[3:0]} only if shift counter == 8; otherwise discard, set frame_err, change nothing else.
REQ-013 op 00 (NOP) SHALL clear frame_err.
REQ-014 op 01 (WRITE) SHALL load row register [addr] with data and clear frame_err; visible on LEDS_columns the edge after UPDATE when that row is selected.
REQ-015 op 10 (READ) SHALL latch row register [addr] into rd_data, clear frame_err; returned by the next CAPTURE.
REQ-016 op 11 (SCAN) SHALL set scan_en = data[0], clear row pointer and dwell counter, clear frame_err.
REQ-017 With scan_en=0, LEDS_rows SHALL be 4'b0001 and LEDS_columns row register 0.
REQ-018 With scan_en=1, dwell counter SHALL increment only on edges with JRTI2=1, hold otherwise; at DWELL-1 it SHALL wrap to 0 and row pointer SHALL advance, wrapping 3 -> 0.
REQ-019 LEDS_rows SHALL equal one-hot(row_ptr) and LEDS_columns row register [row_ptr], both registered, updating the edge after row_ptr changes.
REQ-020 UPDATE coincident with JRTI2=1 SHALL apply the command; a SCAN command overrides the dwell advance on that edge.
REQ-021 Shift counter SHALL saturate at 15; frames of 16+ bits are rejected per REQ-012.

Reset
REQ-022 SHALL, on any edge with JRSTN=0, clear shift register, counters, row registers, rd_data, scan_en, frame_err, row_ptr, JTD2=0, LEDS_columns=0, LEDS_rows=4'b0001; mid-shift reset discards the frame.
REQ-023 SHALL resume normal decode on the first edge with JRSTN=1.

Structure
REQ-024 SHALL place opcode constants (NOP, WRITE, READ, SCAN), frame field positions, and frame length 8 in shared package jtag_led_pkg.
REQ-025 SHALL instantiate one sub-module led_row_scanner (dwell counter, row pointer, output registers); all JTAG decode stays in jtag_led_ctrl.

Verification
REQ-026 Reset, shift WRITE frame 8'h5A (op 01, addr 1, data A) with 8 SHIFT cycles, UPDATE -> row1=4'hA; LEDS_columns stays 0 (row 0 selected).
REQ-027 After REQ-026, READ frame 8'h90 (addr 1), UPDATE, CAPTURE, shift 8 -> JTD2 LSB-first 0,1,0,1,0,0,0,0 (rd_data A, scan_en 0, err 0, row 0).
REQ-028 Shift 7 bits then UPDATE -> no register change; next CAPTURE bit5=1; NOP frame 8'h00 then clears it.
REQ-029 DWELL=4, rows = 1,2,4,8, SCAN frame 8'hC1, JRTI2=1 steady -> LEDS_rows 0001,0010,0100,1000,0001 each held 4 cycles, columns 1,2,4,8; JRTI2=0 freezes them.
REQ-030 JRSTN=0 for one edge during SHIFT of bit 4 -> all outputs at reset values next edge; following full WRITE frame applies normally.
